// File: rtl/scan_seq_ctrl.sv
// Scan chain sequencer: serial load, capture, serial unload of one mux-D chain.
// One shift register serves both load and unload; scan_se is registered.
module scan_seq_ctrl #(
    parameter int CHAIN_LEN  = 32,
    parameter int CAP_CYCLES = 1,
    parameter int CNT_W      = $clog2(CHAIN_LEN + CAP_CYCLES + 1)
) (
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [CHAIN_LEN-1:0] cmd_pattern,
    output logic                 scan_se,
    output logic                 scan_si,
    input  logic                 scan_so,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [CHAIN_LEN-1:0] resp_data,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_CAPTURE,
        S_UNLOAD,
        S_RESP
    } state_t;

    localparam logic [CNT_W-1:0] LAST_SH  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] LAST_CAP = CNT_W'(CAP_CYCLES - 1);

    state_t                 r_state;
    state_t                 w_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CHAIN_LEN-1:0]   r_sreg;
    logic                   w_scan_phase;
    logic                   w_cnt_en;

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            S_IDLE:    if (cmd_valid)          w_nxt = S_SHIFT;
            S_SHIFT:   if (r_cnt == LAST_SH)   w_nxt = S_CAPTURE;
            S_CAPTURE: if (r_cnt == LAST_CAP)  w_nxt = S_UNLOAD;
            S_UNLOAD:  if (r_cnt == LAST_SH)   w_nxt = S_RESP;
            S_RESP:    if (resp_ready)         w_nxt = S_IDLE;
            default:                           w_nxt = S_IDLE;
        endcase
    end

    assign w_scan_phase = (r_state == S_SHIFT) || (r_state == S_UNLOAD);
    assign w_cnt_en     = w_scan_phase || (r_state == S_CAPTURE);

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_sreg     <= '0;
            scan_se    <= 1'b0;
            resp_valid <= 1'b0;
        end else begin
            r_state    <= w_nxt;
            // Decoded from next state so scan_se lines up with the shift edges
            scan_se    <= (w_nxt == S_SHIFT) || (w_nxt == S_UNLOAD);
            resp_valid <= (w_nxt == S_RESP);
            if ((w_nxt != r_state) || !w_cnt_en)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
            if ((r_state == S_IDLE) && cmd_valid)
                r_sreg <= cmd_pattern;
            else if (w_scan_phase)
                r_sreg <= {r_sreg[CHAIN_LEN-2:0], scan_so};
        end
    end

    // Unload zero-fills, so only the load phase exposes sreg on scan_si
    assign scan_si   = (r_state == S_SHIFT) & r_sreg[CHAIN_LEN-1];
    assign resp_data = r_sreg;
    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_scan_seq_ctrl.sv
// Directed bench for scan_seq_ctrl with inverting-capture chain models.
// Three instances: 8-flop/1 capture, 8-flop/2 capture, 2-flop/1 capture.
module tb_scan_seq_ctrl;

    logic       clk;
    logic       rst;
    logic [2:0] cv;
    logic [2:0] rr;
    logic [7:0] cp [3];
    wire  [2:0] crdy, se, si, so, rv, bsy;
    wire  [7:0] rd0, rd1;
    wire  [1:0] rd2;
    logic [7:0] ch0, ch1;
    logic [1:0] ch2;
    int         n_chk;
    int         n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    scan_seq_ctrl #(.CHAIN_LEN(8), .CAP_CYCLES(1)) u_a (
        .nvdla_core_clk(clk), .nvdla_core_rst(rst),
        .cmd_valid(cv[0]), .cmd_ready(crdy[0]), .cmd_pattern(cp[0]),
        .scan_se(se[0]), .scan_si(si[0]), .scan_so(so[0]),
        .resp_valid(rv[0]), .resp_ready(rr[0]), .resp_data(rd0),
        .busy(bsy[0])
    );

    scan_seq_ctrl #(.CHAIN_LEN(8), .CAP_CYCLES(2)) u_b (
        .nvdla_core_clk(clk), .nvdla_core_rst(rst),
        .cmd_valid(cv[1]), .cmd_ready(crdy[1]), .cmd_pattern(cp[1]),
        .scan_se(se[1]), .scan_si(si[1]), .scan_so(so[1]),
        .resp_valid(rv[1]), .resp_ready(rr[1]), .resp_data(rd1),
        .busy(bsy[1])
    );

    scan_seq_ctrl #(.CHAIN_LEN(2), .CAP_CYCLES(1)) u_c (
        .nvdla_core_clk(clk), .nvdla_core_rst(rst),
        .cmd_valid(cv[2]), .cmd_ready(crdy[2]), .cmd_pattern(cp[2][1:0]),
        .scan_se(se[2]), .scan_si(si[2]), .scan_so(so[2]),
        .resp_valid(rv[2]), .resp_ready(rr[2]), .resp_data(rd2),
        .busy(bsy[2])
    );

    // Mux-D chains: shift toward the MSB when scan_se, else D = ~Q
    always @(posedge clk) begin
        if (rst) begin
            ch0 <= '0;
            ch1 <= '0;
            ch2 <= '0;
        end else begin
            ch0 <= se[0] ? {ch0[6:0], si[0]} : ~ch0;
            ch1 <= se[1] ? {ch1[6:0], si[1]} : ~ch1;
            ch2 <= se[2] ? {ch2[0], si[2]} : ~ch2;
        end
    end

    assign so = {ch2[1], ch1[7], ch0[7]};

    function automatic logic [7:0] rdat(input int k);
        case (k)
            0:       return rd0;
            1:       return rd1;
            default: return {6'b0, rd2};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_rv(input int k, output int n);
        n = 1;
        while (rv[k] !== 1'b1 && n < 80) begin
            tick();
            n++;
        end
    endtask

    task automatic do_cmd(input int k, input int L, input int C,
                          input logic [7:0] pat, input logic [7:0] exp_rd,
                          input int exp_lat, input string tag);
        int n, se_err, si_err, lo;
        chk({tag, "_rdy"}, 32'(crdy[k]), 32'd1);
        cv[k] = 1'b1;
        cp[k] = pat;
        rr[k] = 1'b1;
        tick();
        cv[k] = 1'b0;
        cp[k] = ~pat;
        n = 1;
        se_err = 0;
        si_err = 0;
        lo = 0;
        while (rv[k] !== 1'b1 && n < 80) begin
            if (se[k] !== ((n <= L) || (n > L + C))) se_err++;
            if (se[k] === 1'b0) lo++;
            if (si[k] !== ((n <= L) ? pat[L-n] : 1'b0)) si_err++;
            tick();
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        chk({tag, "_se"}, 32'(se_err), 32'd0);
        chk({tag, "_si"}, 32'(si_err), 32'd0);
        chk({tag, "_selow"}, 32'(lo), 32'(C));
        chk({tag, "_rd"}, 32'(rdat(k)), 32'(exp_rd));
        tick();
        chk({tag, "_rvdone"}, 32'(rv[k]), 32'd0);
        chk({tag, "_rdyback"}, 32'(crdy[k]), 32'd1);
    endtask

    initial begin
        int n, bad;
        logic [7:0] held;
        n_chk = 0;
        n_pass = 0;
        rst = 1'b1;
        cv = '0;
        rr = '0;
        for (int i = 0; i < 3; i++) cp[i] = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        chk("rst_se", 32'(se[0]), 32'd0);
        chk("rst_si", 32'(si[0]), 32'd0);
        chk("rst_rv", 32'(rv[0]), 32'd0);
        chk("rst_busy", 32'(bsy[0]), 32'd0);
        chk("rst_rdy", 32'(crdy), 32'd7);
        chk("rst_rd", 32'(rd0), 32'd0);

        do_cmd(0, 8, 1, 8'hA5, 8'h5A, 18, "a5");
        do_cmd(1, 8, 2, 8'h3C, 8'h3C, 19, "3c");
        do_cmd(2, 2, 1, 8'h01, 8'h02, 6, "len2");

        // Stall the response and offer a command that must be ignored
        rr[0] = 1'b0;
        cv[0] = 1'b1;
        cp[0] = 8'h0F;
        tick();
        cv[0] = 1'b0;
        wait_rv(0, n);
        chk("hold_lat", 32'(n), 32'd18);
        chk("hold_rd", 32'(rd0), 32'hF0);
        held = rd0;
        cv[0] = 1'b1;
        cp[0] = 8'h81;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rv[0] !== 1'b1 || rd0 !== held || crdy[0] !== 1'b0) bad++;
        end
        chk("hold_stable", 32'(bad), 32'd0);
        rr[0] = 1'b1;
        tick();
        chk("hold_rdy", 32'(crdy[0]), 32'd1);
        chk("hold_rvlow", 32'(rv[0]), 32'd0);
        tick();
        chk("hold_accept", 32'(bsy[0]), 32'd1);
        cv[0] = 1'b0;
        wait_rv(0, n);
        chk("hold2_lat", 32'(n), 32'd18);
        chk("hold2_rd", 32'(rd0), 32'h7E);
        tick();
        chk("hold2_idle", 32'(bsy[0]), 32'd0);

        // Reset in the 4th shift cycle, then a fresh command
        cv[0] = 1'b1;
        cp[0] = 8'h3C;
        tick();
        cv[0] = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_shift", 32'(se[0]), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_se", 32'(se[0]), 32'd0);
        chk("mrst_busy", 32'(bsy[0]), 32'd0);
        chk("mrst_rv", 32'(rv[0]), 32'd0);
        chk("mrst_rd", 32'(rd0), 32'd0);
        do_cmd(0, 8, 1, 8'hFF, 8'h00, 18, "ff");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
